// File: rtl/mem_router_nch.sv
// Address-decoding router from one host memory port to N_CH targets, with in-order responses via a channel lock.
// Optional watchdog/flush path is enabled with `define MEM_ROUTER_TIMEOUT_EN.
module mem_router_nch #(
   parameter int MEM_W       = 32,
   parameter int N_CH        = 4,
   parameter int SEL_LSB     = 28,
   parameter int MAX_OUTST   = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  host_req_i,
   input  logic [31:0]           host_addr_i,
   input  logic                  host_we_i,
   input  logic [MEM_W/8-1:0]    host_be_i,
   input  logic [MEM_W-1:0]      host_wdata_i,
   output logic                  host_gnt_o,
   output logic                  host_rvalid_o,
   output logic                  host_err_o,
   output logic [MEM_W-1:0]      host_rdata_o,
   output logic [N_CH-1:0]       tgt_req_o,
   output logic [31:0]           tgt_addr_o,
   output logic                  tgt_we_o,
   output logic [MEM_W/8-1:0]    tgt_be_o,
   output logic [MEM_W-1:0]      tgt_wdata_o,
   input  logic [N_CH-1:0]       tgt_gnt_i,
   input  logic [N_CH-1:0]       tgt_rvalid_i,
   input  logic [N_CH-1:0]       tgt_err_i,
   input  logic [N_CH*MEM_W-1:0] tgt_rdata_i
);

   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   if (N_CH < 1 || N_CH > 16 || MAX_OUTST < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("mem_router_nch: illegal parameter combination");
   end

`ifdef MEM_ROUTER_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_e;
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
`else
   typedef enum logic [1:0] {IDLE, BUSY} state_e;
`endif

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   outst_cnt_q, outst_cnt_d;
   logic [3:0]         lock_ch_q, lock_ch_d;
   logic               dec_err_pend_q, dec_err_pend_d;
   logic               rvalid_q, rvalid_d;
   logic               err_q, err_d;
   logic [MEM_W-1:0]   rdata_q, rdata_d;

   logic [3:0]         sel;
   logic               mapped, fwd_ok, unmap_ok, sel_gnt;
   logic               acc_map, acc_unmap, rsp_hit;
   logic               lock_rv, lock_err;
   logic [MEM_W-1:0]   lock_rdata;

   assign tgt_addr_o    = host_addr_i;
   assign tgt_we_o      = host_we_i;
   assign tgt_be_o      = host_be_i;
   assign tgt_wdata_o   = host_wdata_i;
   assign host_rvalid_o = rvalid_q;
   assign host_err_o    = err_q;
   assign host_rdata_o  = rdata_q;

   // Decode and channel muxing; only the locked channel's response is ever observed.
   always_comb begin
      sel        = host_addr_i[SEL_LSB+3:SEL_LSB];
      mapped     = int'(sel) < N_CH;
      sel_gnt    = 1'b0;
      lock_rv    = 1'b0;
      lock_err   = 1'b0;
      lock_rdata = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (sel == 4'(k)) begin
            sel_gnt = tgt_gnt_i[k];
         end
         if (lock_ch_q == 4'(k)) begin
            lock_rv    = tgt_rvalid_i[k];
            lock_err   = tgt_err_i[k];
            lock_rdata = tgt_rdata_i[k*MEM_W +: MEM_W];
         end
      end
      fwd_ok = mapped && ((state_q == IDLE) ||
               ((state_q == BUSY) && (sel == lock_ch_q) && (outst_cnt_q < CNT_W'(MAX_OUTST))));
      unmap_ok  = !mapped && (state_q == IDLE) && !dec_err_pend_q;
      acc_map   = host_req_i && fwd_ok && sel_gnt;
      acc_unmap = host_req_i && unmap_ok;
      rsp_hit   = (state_q == BUSY) && lock_rv;
      host_gnt_o = acc_map || acc_unmap;
      tgt_req_o = '0;
      for (int k = 0; k < N_CH; k++) begin
         tgt_req_o[k] = host_req_i && fwd_ok && (sel == 4'(k));
      end
   end

   always_comb begin
      state_d        = state_q;
      outst_cnt_d    = outst_cnt_q;
      lock_ch_d      = lock_ch_q;
      dec_err_pend_d = acc_unmap;
      rvalid_d       = acc_unmap;
      err_d          = acc_unmap;
      rdata_d        = '0;
`ifdef MEM_ROUTER_TIMEOUT_EN
      wd_d = ((state_q == BUSY) && !acc_map && !rsp_hit) ? wd_q + WD_W'(1) : '0;
`endif
      case (state_q)
         IDLE: begin
            if (acc_map) begin
               state_d     = BUSY;
               lock_ch_d   = sel;
               outst_cnt_d = CNT_W'(1);
            end
         end
         BUSY: begin
            if (rsp_hit) begin
               rvalid_d = 1'b1;
               err_d    = lock_err;
               rdata_d  = lock_rdata;
            end
            if (acc_map && !rsp_hit) begin
               outst_cnt_d = outst_cnt_q + CNT_W'(1);
            end else if (!acc_map && rsp_hit) begin
               outst_cnt_d = outst_cnt_q - CNT_W'(1);
               if (outst_cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
               end
            end
`ifdef MEM_ROUTER_TIMEOUT_EN
            if (!acc_map && !rsp_hit && (wd_q == WD_W'(TIMEOUT_CYC - 1))) begin
               state_d = FLUSH;
            end
         end
         // Drain one synthetic error per outstanding request; real responses are dropped.
         FLUSH: begin
            rvalid_d    = 1'b1;
            err_d       = 1'b1;
            outst_cnt_d = outst_cnt_q - CNT_W'(1);
            if (outst_cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         outst_cnt_q    <= '0;
         lock_ch_q      <= '0;
         dec_err_pend_q <= 1'b0;
         rvalid_q       <= 1'b0;
         err_q          <= 1'b0;
         rdata_q        <= '0;
`ifdef MEM_ROUTER_TIMEOUT_EN
         wd_q           <= '0;
`endif
      end else begin
         state_q        <= state_d;
         outst_cnt_q    <= outst_cnt_d;
         lock_ch_q      <= lock_ch_d;
         dec_err_pend_q <= dec_err_pend_d;
         rvalid_q       <= rvalid_d;
         err_q          <= err_d;
         rdata_q        <= rdata_d;
`ifdef MEM_ROUTER_TIMEOUT_EN
         wd_q           <= wd_d;
`endif
      end
   end

endmodule
